alu: RTL and testbench
======================

ALU -- requirements
Module: ALU

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result datapath width; all values below assume WIDTH=8.
REQ-002 clk  input  1  SHALL be the single clock; its rising edge updates the stored carry.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 operation  input  4  SHALL be the opcode select.
REQ-005 operand1  input  WIDTH  SHALL be operand A.
REQ-006 operand2  input  WIDTH  SHALL be operand B.
REQ-007 carry_we  input  1  SHALL, when 1, store carry_flag into the internal carry register on the rising clk edge.
REQ-008 result  output  WIDTH  SHALL be the operation result.
REQ-009 zero_flag  output  1  SHALL be 1 when result equals 0.
REQ-010 carry_flag  output  1  SHALL be the carry / not-borrow / shifted-out bit.
REQ-011 overflow_flag  output  1  SHALL be the signed two's-complement overflow.
REQ-012 negative_flag  output  1  SHALL equal result[WIDTH-1].

Function
REQ-013 result and all four flags SHALL be purely combinational from operation, operand1, operand2 and the carry register, with zero clock latency.
REQ-014 The opcodes SHALL be as follows:
- 0x0 ADD: A+B.
- 0x1 SUB: A-B.
- 0x2 AND.
- 0x3 OR.
- 0x4 XOR.
- 0x5 NOT: ~A.
- 0x6 SHL: A<<1.
- 0x7 SHR: logical A>>1.
- 0x8 ADC: A+B+Creg.
- 0x9 SBB: A-B-(1-Creg).
- 0xA INC: A+1.
- 0xB DEC: A-1.
- 0xC CMP: flags of A-B, with result = A.
- 0xD ASR: arithmetic A>>1.
- 0xE PASS: B.
- 0xF NOP: result 0.
REQ-015 Arithmetic SHALL be computed at WIDTH+1 bits, and result SHALL be the low WIDTH bits (wrap-around).
REQ-016 For add-type operations (ADD, ADC, INC), carry_flag SHALL be bit WIDTH of the sum.
REQ-017 For add-type operations, overflow_flag SHALL be 1 when both addends share a sign and the result sign differs.
REQ-018 For subtract-type operations (SUB, SBB, DEC, CMP), carry_flag SHALL be 1 when no borrow occurs (A >= subtrahend, unsigned).
REQ-019 For subtract-type operations, overflow_flag SHALL be 1 when the operand signs differ and the result sign differs from A.
REQ-020 SHL SHALL set carry_flag to A[WIDTH-1].
REQ-021 SHR and ASR SHALL set carry_flag to A[0].
REQ-022 Shift operations SHALL set overflow_flag to 0.
REQ-023 AND, OR, XOR, NOT, PASS and NOP SHALL set carry_flag and overflow_flag to 0.
REQ-024 zero_flag and negative_flag SHALL always be derived from result; for CMP they SHALL be derived from the difference A-B instead.
REQ-025 The internal carry register Creg SHALL load carry_flag on the rising clk edge only when carry_we=1 and rst=0; otherwise it SHALL hold its value.

Reset
REQ-026 Asserting rst SHALL clear Creg to 0 immediately, without waiting for a clock edge.
REQ-027 Creg SHALL stay at 0 while rst is high.
REQ-028 Combinational outputs SHALL remain valid during reset, with ADC and SBB evaluated using Creg=0.
REQ-029 A carry_we write coinciding with rst SHALL be ignored.

Verification
REQ-030 ADD 10,5 -> result 15, Z0 C0 V0 N0; ADD 255,1 -> result 0, Z1 C1 V0; ADD 127,1 -> result 128, Z0 C0 V1 N1.
REQ-031 SUB 10,5 -> result 5, C1 V0; SUB 0,1 -> result 255, Z0 C0 V0 N1; CMP 7,7 -> result 7, Z1 C1.
REQ-032 AND 0xAA,0xF0 -> 0xA0, C0 V0; XOR 0xFF,0xFF -> 0x00, Z1 C0 V0.
REQ-033 ADD 0xFF,0x01 with carry_we=1 and one clk edge, then ADC 0x00,0x00 -> result 1, C0.
REQ-034 After rst is pulsed, ADC 0x00,0x00 -> result 0, Z1.
REQ-035 SHL 0x81 -> 0x02, C1; SHR 0x81 -> 0x40, C1; ASR 0x80 -> 0xC0, N1 C0.

Source files
------------

// File: rtl/alu.sv
// Combinational ALU with a stored carry for multi-word ADC/SBB chains.
// Flags follow the usual carry / not-borrow convention.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             carry_we,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             negative_flag
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_ADC  = 4'h8;
    localparam logic [3:0] OP_SBB  = 4'h9;
    localparam logic [3:0] OP_INC  = 4'hA;
    localparam logic [3:0] OP_DEC  = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_ASR  = 4'hD;
    localparam logic [3:0] OP_PASS = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam int MSB = WIDTH - 1;

    logic             creg;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sub_b;
    logic             cin;
    logic             bin;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_v;
    logic             sub_v;
    logic [WIDTH-1:0] flag_src;

    always_comb begin
        add_b = operand2;
        sub_b = operand2;
        cin   = 1'b0;
        bin   = 1'b0;
        case (operation)
            OP_ADC:  cin   = creg;
            OP_INC:  add_b = ONE;
            OP_SBB:  bin   = ~creg;
            OP_DEC:  sub_b = ONE;
            default: ;
        endcase
    end

    // Borrow out of the WIDTH+1 bit difference shows up in the top bit.
    assign sum  = {1'b0, operand1} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin};
    assign diff = {1'b0, operand1} - {1'b0, sub_b} - {{WIDTH{1'b0}}, bin};

    assign add_v = (operand1[MSB] == add_b[MSB]) && (sum[MSB] != operand1[MSB]);
    assign sub_v = (operand1[MSB] != sub_b[MSB]) && (diff[MSB] != operand1[MSB]);

    always_comb begin
        result        = '0;
        carry_flag    = 1'b0;
        overflow_flag = 1'b0;
        unique case (operation)
            OP_ADD, OP_ADC, OP_INC: begin
                result        = sum[WIDTH-1:0];
                carry_flag    = sum[WIDTH];
                overflow_flag = add_v;
            end
            OP_SUB, OP_SBB, OP_DEC: begin
                result        = diff[WIDTH-1:0];
                carry_flag    = ~diff[WIDTH];
                overflow_flag = sub_v;
            end
            OP_CMP: begin
                result        = operand1;
                carry_flag    = ~diff[WIDTH];
                overflow_flag = sub_v;
            end
            OP_AND:  result = operand1 & operand2;
            OP_OR:   result = operand1 | operand2;
            OP_XOR:  result = operand1 ^ operand2;
            OP_NOT:  result = ~operand1;
            OP_SHL: begin
                result     = {operand1[WIDTH-2:0], 1'b0};
                carry_flag = operand1[MSB];
            end
            OP_SHR: begin
                result     = {1'b0, operand1[WIDTH-1:1]};
                carry_flag = operand1[0];
            end
            OP_ASR: begin
                result     = {operand1[MSB], operand1[WIDTH-1:1]};
                carry_flag = operand1[0];
            end
            OP_PASS: result = operand2;
            OP_NOP:  result = '0;
        endcase
    end

    // CMP reports Z/N of the difference while passing A through.
    assign flag_src      = (operation == OP_CMP) ? diff[WIDTH-1:0] : result;
    assign zero_flag     = (flag_src == '0);
    assign negative_flag = flag_src[MSB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            creg <= 1'b0;
        else if (carry_we)
            creg <= carry_flag;
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: combinational ops, stored carry
// chaining and asynchronous reset behaviour.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [3:0] operation;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic       carry_we;
    logic [7:0] result;
    logic       zero_flag;
    logic       carry_flag;
    logic       overflow_flag;
    logic       negative_flag;

    int n_vec;
    int n_bad;

    logic [11:0] got;
    logic [11:0] exp_v;

    alu #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .operation     (operation),
        .operand1      (operand1),
        .operand2      (operand2),
        .carry_we      (carry_we),
        .result        (result),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .negative_flag (negative_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign got = {result, zero_flag, carry_flag, overflow_flag, negative_flag};

    // {op, A, B, result, Z C V N}
    localparam logic [31:0] ARITH [12] = '{
        {4'h0, 8'h0A, 8'h05, 8'h0F, 4'b0000},
        {4'h0, 8'hFF, 8'h01, 8'h00, 4'b1100},
        {4'h0, 8'h7F, 8'h01, 8'h80, 4'b0011},
        {4'h1, 8'h0A, 8'h05, 8'h05, 4'b0100},
        {4'h1, 8'h00, 8'h01, 8'hFF, 4'b0001},
        {4'h1, 8'h80, 8'h01, 8'h7F, 4'b0110},
        {4'hC, 8'h07, 8'h07, 8'h07, 4'b1100},
        {4'hC, 8'h05, 8'h07, 8'h05, 4'b0001},
        {4'hA, 8'hFF, 8'h00, 8'h00, 4'b1100},
        {4'hA, 8'h7F, 8'h00, 8'h80, 4'b0011},
        {4'hB, 8'h00, 8'h00, 8'hFF, 4'b0001},
        {4'hB, 8'h80, 8'h00, 8'h7F, 4'b0110}
    };

    localparam logic [31:0] LOGIC [6] = '{
        {4'h2, 8'hAA, 8'hF0, 8'hA0, 4'b0001},
        {4'h3, 8'h0F, 8'hF0, 8'hFF, 4'b0001},
        {4'h4, 8'hFF, 8'hFF, 8'h00, 4'b1000},
        {4'h5, 8'h0F, 8'h33, 8'hF0, 4'b0001},
        {4'hE, 8'h00, 8'h5A, 8'h5A, 4'b0000},
        {4'hF, 8'h12, 8'h34, 8'h00, 4'b1000}
    };

    localparam logic [31:0] SHIFT [5] = '{
        {4'h6, 8'h81, 8'h00, 8'h02, 4'b0100},
        {4'h7, 8'h81, 8'h00, 8'h40, 4'b0100},
        {4'hD, 8'h80, 8'h00, 8'hC0, 4'b0001},
        {4'h6, 8'h40, 8'h00, 8'h80, 4'b0001},
        {4'hD, 8'h41, 8'h00, 8'h20, 4'b0100}
    };

    task automatic drive(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic we);
        operation = op;
        operand1  = a;
        operand2  = b;
        carry_we  = we;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(4'h8, 8'h00, 8'h00, 1'b0);
        n_vec++;
        if (got !== {8'h00, 4'b1000}) begin
            n_bad++;
            $display("FAIL reset_adc got=%h exp=%h", got, {8'h00, 4'b1000});
        end
        drive(4'h9, 8'h00, 8'h00, 1'b0);
        n_vec++;
        if (got !== {8'hFF, 4'b0001}) begin
            n_bad++;
            $display("FAIL reset_sbb got=%h exp=%h", got, {8'hFF, 4'b0001});
        end
        // carry write while in reset must be dropped
        @(negedge clk);
        drive(4'h0, 8'hFF, 8'h01, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        drive(4'h8, 8'h00, 8'h00, 1'b0);
        n_vec++;
        if (got !== {8'h00, 4'b1000}) begin
            n_bad++;
            $display("FAIL reset_we_ignored got=%h exp=%h", got, {8'h00, 4'b1000});
        end
    endtask

    task automatic test_table(input string name, input int kind);
        int n;
        logic [31:0] v;
        n = (kind == 0) ? 12 : (kind == 1) ? 6 : 5;
        for (int i = 0; i < n; i++) begin
            v = (kind == 0) ? ARITH[i] : (kind == 1) ? LOGIC[i] : SHIFT[i];
            @(negedge clk);
            drive(v[31:28], v[27:20], v[19:12], 1'b0);
            exp_v = v[11:0];
            n_vec++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL %s[%0d] op=%h a=%h b=%h got=%h exp=%h",
                         name, i, v[31:28], v[27:20], v[19:12], got, exp_v);
            end
        end
    endtask

    task automatic test_carry_chain;
        @(negedge clk);
        drive(4'h0, 8'hFF, 8'h01, 1'b1);
        @(posedge clk);
        #1;
        drive(4'h8, 8'h00, 8'h00, 1'b0);
        n_vec++;
        if (got !== {8'h01, 4'b0000}) begin
            n_bad++;
            $display("FAIL adc_c1 got=%h exp=%h", got, {8'h01, 4'b0000});
        end
        drive(4'h9, 8'h05, 8'h05, 1'b0);
        n_vec++;
        if (got !== {8'h00, 4'b1100}) begin
            n_bad++;
            $display("FAIL sbb_c1 got=%h exp=%h", got, {8'h00, 4'b1100});
        end
        @(negedge clk);
        drive(4'h0, 8'h0A, 8'h05, 1'b1);
        @(posedge clk);
        #1;
        drive(4'h8, 8'h00, 8'h00, 1'b0);
        n_vec++;
        if (got !== {8'h00, 4'b1000}) begin
            n_bad++;
            $display("FAIL adc_c0 got=%h exp=%h", got, {8'h00, 4'b1000});
        end
        drive(4'h9, 8'h05, 8'h05, 1'b0);
        n_vec++;
        if (got !== {8'hFF, 4'b0001}) begin
            n_bad++;
            $display("FAIL sbb_c0 got=%h exp=%h", got, {8'hFF, 4'b0001});
        end
        // without carry_we the register holds 0
        @(negedge clk);
        drive(4'h0, 8'hFF, 8'h01, 1'b0);
        @(posedge clk);
        #1;
        drive(4'h8, 8'h00, 8'h00, 1'b0);
        n_vec++;
        if (got !== {8'h00, 4'b1000}) begin
            n_bad++;
            $display("FAIL adc_hold got=%h exp=%h", got, {8'h00, 4'b1000});
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        drive(4'h0, 8'hFF, 8'h01, 1'b1);
        @(posedge clk);
        #1;
        drive(4'h8, 8'h01, 8'h00, 1'b1);
        n_vec++;
        if (got !== {8'h02, 4'b0000}) begin
            n_bad++;
            $display("FAIL b2b_hi got=%h exp=%h", got, {8'h02, 4'b0000});
        end
        @(posedge clk);
        #1;
        drive(4'h8, 8'h00, 8'h00, 1'b0);
        n_vec++;
        if (got !== {8'h00, 4'b1000}) begin
            n_bad++;
            $display("FAIL b2b_after got=%h exp=%h", got, {8'h00, 4'b1000});
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        drive(4'h0, 8'hFF, 8'h01, 1'b1);
        @(posedge clk);
        #1;
        drive(4'h8, 8'h00, 8'h00, 1'b0);
        n_vec++;
        if (got !== {8'h01, 4'b0000}) begin
            n_bad++;
            $display("FAIL async_pre got=%h exp=%h", got, {8'h01, 4'b0000});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (got !== {8'h00, 4'b1000}) begin
            n_bad++;
            $display("FAIL async_clear got=%h exp=%h", got, {8'h00, 4'b1000});
        end
        #2;
        rst = 1'b0;
        @(negedge clk);
        drive(4'h8, 8'h00, 8'h00, 1'b0);
        n_vec++;
        if (got !== {8'h00, 4'b1000}) begin
            n_bad++;
            $display("FAIL async_after got=%h exp=%h", got, {8'h00, 4'b1000});
        end
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        operation = 4'h0;
        operand1  = 8'h00;
        operand2  = 8'h00;
        carry_we  = 1'b0;
        test_reset;
        test_table("arith", 0);
        test_table("logic", 1);
        test_table("shift", 2);
        test_carry_chain;
        test_back_to_back;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
